// File: rtl/axi_pkg.sv
// Shared AXI definitions for the interconnect: bus field widths, response
// codes, and the state types used by the default (decode-error) slave.
package axi_pkg;

    localparam int unsigned AXI_IDS_BITS  = 8;
    localparam int unsigned AXI_LEN_BITS  = 4;
    localparam int unsigned AXI_DATA_BITS = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/default_slave_rd.sv
// Read channel of the default slave. It accepts one AR request at a time and
// returns ARLEN+1 beats of DEFAULT_RDATA with DECERR_RESP, RLAST on the final beat.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   arid_i, arlen_i       AR ID and burst length minus 1
//   arvalid_i/arready_o   AR handshake
//   rid_o, rdata_o,
//   rresp_o, rlast_o      R beat payload
//   rvalid_o/rready_i     R handshake
module default_slave_rd
    import axi_pkg::*;
#(
    parameter logic [1:0]               DECERR_RESP   = AXI_RESP_DECERR,
    parameter logic [AXI_DATA_BITS-1:0] DEFAULT_RDATA = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AXI_IDS_BITS-1:0]  arid_i,
    input  logic [AXI_LEN_BITS-1:0]  arlen_i,
    input  logic                     arvalid_i,
    output logic                     arready_o,
    output logic [AXI_IDS_BITS-1:0]  rid_o,
    output logic [AXI_DATA_BITS-1:0] rdata_o,
    output logic [1:0]               rresp_o,
    output logic                     rlast_o,
    output logic                     rvalid_o,
    input  logic                     rready_i
);

    r_state_t                state_q, state_d;
    logic [AXI_IDS_BITS-1:0] id_q, id_d;
    logic [AXI_LEN_BITS-1:0] len_q, len_d;
    logic [AXI_LEN_BITS-1:0] cnt_q, cnt_d;
    logic                    last_beat;

    // Compare before increment: the final beat ends the burst instead of
    // advancing the counter, so cnt_q never wraps even for a 16-beat burst.
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    id_d    = arid_i;
                    len_d   = arlen_i;
                    cnt_d   = '0;
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    assign arready_o = !rst_i && (state_q == R_IDLE);
    assign rvalid_o  = !rst_i && (state_q == R_DATA);
    assign rlast_o   = !rst_i && (state_q == R_DATA) && last_beat;
    assign rid_o     = rst_i ? '0 : id_q;
    assign rdata_o   = DEFAULT_RDATA;
    assign rresp_o   = DECERR_RESP;

endmodule

// File: rtl/axi_default_slave.sv
// Default (decode-error) AXI slave. Every transaction steered here is
// completed with DECERR: reads return ARLEN+1 beats of DEFAULT_RDATA, and
// writes drain W beats until WLAST and then return one B response. The
// read and write channels run independently.
// Ports:
//   ACLK, ARESET                        clock, synchronous active-high reset
//   AR*_DS / R*_DS                      read address and read data channels
//   AW*_DS / W*_DS / B*_DS              write address, data, response channels
module axi_default_slave
    import axi_pkg::*;
#(
    parameter logic [1:0]               DECERR_RESP   = AXI_RESP_DECERR,
    parameter logic [AXI_DATA_BITS-1:0] DEFAULT_RDATA = 32'h0000_0000
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [AXI_IDS_BITS-1:0]  ARID_DS,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_DS,
    input  logic                     ARVALID_DS,
    output logic                     ARREADY_DS,
    output logic [AXI_IDS_BITS-1:0]  RID_DS,
    output logic [AXI_DATA_BITS-1:0] RDATA_DS,
    output logic [1:0]               RRESP_DS,
    output logic                     RLAST_DS,
    output logic                     RVALID_DS,
    input  logic                     RREADY_DS,
    input  logic [AXI_IDS_BITS-1:0]  AWID_DS,
    input  logic                     AWVALID_DS,
    output logic                     AWREADY_DS,
    input  logic                     WLAST_DS,
    input  logic                     WVALID_DS,
    output logic                     WREADY_DS,
    output logic [AXI_IDS_BITS-1:0]  BID_DS,
    output logic [1:0]               BRESP_DS,
    output logic                     BVALID_DS,
    input  logic                     BREADY_DS
);

    default_slave_rd #(
        .DECERR_RESP   (DECERR_RESP),
        .DEFAULT_RDATA (DEFAULT_RDATA)
    ) u_rd (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .arid_i    (ARID_DS),
        .arlen_i   (ARLEN_DS),
        .arvalid_i (ARVALID_DS),
        .arready_o (ARREADY_DS),
        .rid_o     (RID_DS),
        .rdata_o   (RDATA_DS),
        .rresp_o   (RRESP_DS),
        .rlast_o   (RLAST_DS),
        .rvalid_o  (RVALID_DS),
        .rready_i  (RREADY_DS)
    );

    w_state_t                w_state_q, w_state_d;
    logic [AXI_IDS_BITS-1:0] bid_q, bid_d;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
        end
    end

    // W data is ignored; only WLAST terminates the burst, regardless of how
    // many beats were sent.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID_DS) begin
                    bid_d     = AWID_DS;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID_DS && WLAST_DS) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY_DS) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign AWREADY_DS = !ARESET && (w_state_q == W_IDLE);
    assign WREADY_DS  = !ARESET && (w_state_q == W_DATA);
    assign BVALID_DS  = !ARESET && (w_state_q == W_RESP);
    assign BID_DS     = ARESET ? '0 : bid_q;
    assign BRESP_DS   = DECERR_RESP;

endmodule

// File: tb/tb_axi_default_slave.sv
// Testbench for axi_default_slave: a table of per-cycle vectors, directed
// multi-cycle sequences, and randomized traffic against a transaction-level
// model (queue of pending read beats, open write burst, pending B responses).
module tb_axi_default_slave;

    logic       clk;
    logic       rst;
    logic [7:0] arid;
    logic [3:0] arlen;
    logic       arvalid, arready;
    logic [7:0] rid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic       rlast, rvalid, rready;
    logic [7:0] awid;
    logic       awvalid, awready;
    logic       wlast, wvalid, wready;
    logic [7:0] bid;
    logic [1:0] bresp;
    logic       bvalid, bready;

    axi_default_slave #(
        .DECERR_RESP   (2'b11),
        .DEFAULT_RDATA (32'h0000_0000)
    ) dut (
        .ACLK       (clk),
        .ARESET     (rst),
        .ARID_DS    (arid),
        .ARLEN_DS   (arlen),
        .ARVALID_DS (arvalid),
        .ARREADY_DS (arready),
        .RID_DS     (rid),
        .RDATA_DS   (rdata),
        .RRESP_DS   (rresp),
        .RLAST_DS   (rlast),
        .RVALID_DS  (rvalid),
        .RREADY_DS  (rready),
        .AWID_DS    (awid),
        .AWVALID_DS (awvalid),
        .AWREADY_DS (awready),
        .WLAST_DS   (wlast),
        .WVALID_DS  (wvalid),
        .WREADY_DS  (wready),
        .BID_DS     (bid),
        .BRESP_DS   (bresp),
        .BVALID_DS  (bvalid),
        .BREADY_DS  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle vector table ----------------
    typedef struct {
        logic       rst, arv;
        logic [7:0] arid;
        logic [3:0] arlen;
        logic       rrdy, awv;
        logic [7:0] awid;
        logic       wv, wl, brdy;
        logic       e_arr, e_rv, e_rl;
        logic [7:0] e_rid;
        logic       e_awr, e_wr, e_bv;
        logic [7:0] e_bid;
    } vec_t;

    vec_t tbl[14];

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [7:0] id;
        logic       last;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [7:0] bq[$];
    bit         w_open = 1'b0;
    logic [7:0] w_id   = '0;

    // Observation counters fed from DUT handshakes.
    int         acc_rbeats = 0;
    int         rl_cnt = 0;
    int         last_idx = 0;
    int         acc_b = 0;
    logic [7:0] last_bid = '0;
    bit         hold_r = 1'b0, hold_b = 1'b0;
    logic [8:0] hold_r_val = '0;
    logic [7:0] hold_b_val = '0;

    task automatic cycle();
        bit p_arr, p_rv, p_awr, p_wr, p_bv;
        @(negedge clk);
        p_arr = !rst && (rq.size() == 0);
        p_rv  = !rst && (rq.size() != 0);
        p_awr = !rst && !w_open && (bq.size() == 0);
        p_wr  = !rst && w_open;
        p_bv  = !rst && (bq.size() != 0);
        chk("arready", arready, p_arr);
        chk("rvalid", rvalid, p_rv);
        chk("awready", awready, p_awr);
        chk("wready", wready, p_wr);
        chk("bvalid", bvalid, p_bv);
        chk("rdata", rdata, 32'h0);
        chk("rresp", rresp, 2'b11);
        chk("bresp", bresp, 2'b11);
        if (p_rv) begin
            chk("rid", rid, rq[0].id);
            chk("rlast", rlast, rq[0].last);
        end else begin
            chk("rlast_idle", rlast, 0);
        end
        if (p_bv) chk("bid", bid, bq[0]);
        if (rst) begin
            chk("rid_rst", rid, 0);
            chk("bid_rst", bid, 0);
        end
        if (hold_r && !rst) chk("r_stable", {rid, rlast}, hold_r_val);
        if (hold_b && !rst) chk("b_stable", bid, hold_b_val);
        hold_r     = rvalid && !rready;
        hold_r_val = {rid, rlast};
        hold_b     = bvalid && !bready;
        hold_b_val = bid;
        if (rvalid && rready && !rst) begin
            acc_rbeats++;
            if (rlast) begin
                rl_cnt++;
                last_idx = acc_rbeats;
            end
        end
        if (bvalid && bready && !rst) begin
            acc_b++;
            last_bid = bid;
        end
        @(posedge clk);
        if (rst) begin
            rq.delete();
            bq.delete();
            w_open = 1'b0;
        end else begin
            if (p_rv && rready) void'(rq.pop_front());
            if (p_arr && arvalid) begin
                for (int i = 0; i <= int'(arlen); i++) rq.push_back('{arid, (i == int'(arlen))});
            end
            if (p_bv && bready) void'(bq.pop_front());
            if (p_wr && wvalid && wlast) begin
                w_open = 1'b0;
                bq.push_back(w_id);
            end
            if (p_awr && awvalid) begin
                w_open = 1'b1;
                w_id   = awid;
            end
        end
        #1;
    endtask

    task automatic clr_cnt();
        acc_rbeats = 0;
        rl_cnt = 0;
        last_idx = 0;
        acc_b = 0;
        last_bid = '0;
    endtask

    initial begin
        rst = 1'b1; arvalid = 1'b0; arid = '0; arlen = '0; rready = 1'b0;
        awvalid = 1'b0; awid = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;

        //             rst  arv  arid   arlen rrdy awv  awid   wv   wl   brdy | arr  rv   rl   rid    awr  wr   bv   bid
        tbl[0]  = '{1'b1,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        tbl[1]  = '{1'b0,1'b1,8'h5A,4'h0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00};
        tbl[2]  = '{1'b0,1'b0,8'h00,4'h0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,8'h5A,1'b1,1'b0,1'b0,8'h00};
        tbl[3]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00};
        tbl[4]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b1,8'h21,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00};
        tbl[5]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00};
        tbl[6]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00};
        tbl[7]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00};
        tbl[8]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00};
        tbl[9]  = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,8'h00};
        tbl[10] = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,8'h21};
        tbl[11] = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,8'h21};
        tbl[12] = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,8'h21};
        tbl[13] = '{1'b0,1'b0,8'h00,4'h0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00};

        repeat (3) @(posedge clk);
        #1;

        // Table phase: single read, then a 4-beat write with an early W and a W gap.
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; arvalid = tbl[i].arv; arid = tbl[i].arid; arlen = tbl[i].arlen;
            rready = tbl[i].rrdy; awvalid = tbl[i].awv; awid = tbl[i].awid;
            wvalid = tbl[i].wv; wlast = tbl[i].wl; bready = tbl[i].brdy;
            @(negedge clk);
            chk($sformatf("v%0d_arready", i), arready, tbl[i].e_arr);
            chk($sformatf("v%0d_rvalid", i), rvalid, tbl[i].e_rv);
            chk($sformatf("v%0d_rlast", i), rlast, tbl[i].e_rl);
            chk($sformatf("v%0d_awready", i), awready, tbl[i].e_awr);
            chk($sformatf("v%0d_wready", i), wready, tbl[i].e_wr);
            chk($sformatf("v%0d_bvalid", i), bvalid, tbl[i].e_bv);
            chk($sformatf("v%0d_resp", i), {rresp, bresp, rdata}, {2'b11, 2'b11, 32'h0});
            if (tbl[i].e_rv || tbl[i].rst) chk($sformatf("v%0d_rid", i), rid, tbl[i].e_rid);
            if (tbl[i].e_bv || tbl[i].rst) chk($sformatf("v%0d_bid", i), bid, tbl[i].e_bid);
            @(posedge clk);
            #1;
        end

        // Sync model to DUT through a reset cycle.
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0;
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        cycle();
        rst = 1'b0;

        // Max burst with RREADY toggling.
        clr_cnt();
        arvalid = 1'b1; arid = 8'h3C; arlen = 4'hF; rready = 1'b0;
        cycle();
        arvalid = 1'b0;
        for (int k = 0; k < 100 && acc_rbeats < 16; k++) begin
            rready = (k % 2 == 1);
            cycle();
        end
        chk("burst_beats", acc_rbeats, 16);
        chk("burst_rlast_cnt", rl_cnt, 1);
        chk("burst_rlast_at", last_idx, 16);
        rready = 1'b0;
        cycle();

        // Concurrent AR and AW in the same cycle.
        clr_cnt();
        arvalid = 1'b1; arid = 8'h77; arlen = 4'h3; rready = 1'b1;
        awvalid = 1'b1; awid = 8'h99; bready = 1'b1;
        cycle();
        arvalid = 1'b0; awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        cycle();
        wlast = 1'b1;
        cycle();
        wvalid = 1'b0; wlast = 1'b0;
        repeat (6) cycle();
        chk("conc_rbeats", acc_rbeats, 4);
        chk("conc_rid_last", rl_cnt, 1);
        chk("conc_bcount", acc_b, 1);
        chk("conc_bid", last_bid, 8'h99);
        bready = 1'b0;

        // Reset in the middle of an 8-beat burst.
        arvalid = 1'b1; arid = 8'h42; arlen = 4'h7; rready = 1'b0;
        cycle();
        arvalid = 1'b0; rready = 1'b1;
        clr_cnt();
        cycle();
        cycle();
        chk("rst_pre_beats", acc_rbeats, 2);
        rst = 1'b1; rready = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        clr_cnt();
        arvalid = 1'b1; arid = 8'h0E; arlen = 4'h0; rready = 1'b1;
        cycle();
        arvalid = 1'b0;
        repeat (4) cycle();
        chk("rst_post_beats", acc_rbeats, 1);
        chk("rst_post_rlast", rl_cnt, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            arvalid = ($urandom_range(0, 2) == 0);
            arid    = 8'($urandom);
            arlen   = 4'($urandom);
            rready  = ($urandom_range(0, 9) < 7);
            awvalid = ($urandom_range(0, 2) == 0);
            awid    = 8'($urandom);
            wvalid  = ($urandom_range(0, 1) == 0);
            wlast   = ($urandom_range(0, 3) == 0);
            bready  = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
